fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one `fifo` write port among N producers in the pipeline (e.g. debug/trace sources feeding the UART transmit FIFO). Grants the port to one requester at a time, forwards its data and write strobe while the FIFO is not full, and rotates priority after a bounded burst so no producer starves. Sits directly in front of the FIFO's `wr`/`w_data`/`full` pins; the FIFO itself is unchanged.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among N producers.
//   One requester owns the port at a time. While it owns the port, its data and
//   write strobe are forwarded whenever the FIFO is not full. Priority rotates
//   after at most BURST words, or as soon as the owner drops its request, so no
//   producer can starve the others.
//
// Parameters
//   B      data width (matches the FIFO data width)
//   N      number of requesters, 2..16
//   BURST  maximum words written per grant, 1..255
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   req          per-requester "word available" level
//   w_data_in    flattened requester data; slice i is [i*B +: B]
//   fifo_full    FIFO full flag
//   grant        registered one-hot owner of the write port, zero when idle
//   ack          one-hot pulse: the owner's current word is accepted this cycle
//   fifo_wr      FIFO write strobe
//   fifo_w_data  FIFO write data
module fifo_wr_arbiter #(
  parameter int B     = 8,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*B-1:0] w_data_in,
  input  logic           fifo_full,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0] OWNER_MAX = IW'(N - 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          owner_req;
  logic          release_now;
  logic          arbitrate;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] base;
  logic          found;
  logic [IW-1:0] winner;
  logic [N-1:0]  win_onehot;
  int            idx;

  // Datapath toward the FIFO: driven combinationally from the registered owner
  // so that a full flag that drops takes effect in the same cycle.
  // NOTE: every signal written in an always_comb block gets a default value
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    owner_req   = req[owner];
    fifo_wr     = 1'b0;
    ack         = '0;
    fifo_w_data = '0;
    if (state == OWN) begin
      fifo_wr     = owner_req & ~fifo_full;
      ack[owner]  = fifo_wr;
      fifo_w_data = w_data_in[int'(owner)*B +: B];
    end
  end

  // The owner gives up the port when it has nothing to send, or when the
  // BURST-th word goes out this cycle. A stalled owner (FIFO full) keeps
  // its request high and therefore keeps the port.
  always_comb begin
    release_now = (state == OWN) &&
                  (!owner_req || (fifo_wr && (cnt == CNT_LAST)));
    arbitrate   = (state == IDLE) || release_now;
    next_ptr    = (owner == OWNER_MAX) ? '0 : owner + 1'b1;
    // On release the scan starts just past the old owner, so the pointer
    // update and the new grant happen in the same cycle with no dead cycle.
    base        = release_now ? next_ptr : ptr;
  end

  // Round-robin scan: first set request bit at base, base+1, ... modulo N.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    win_onehot = '0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found           = 1'b1;
        winner          = IW'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
    end else begin
      if (release_now) ptr <= next_ptr;

      if (arbitrate) begin
        if (found) begin
          state <= OWN;
          owner <= winner;
          cnt   <= '0;
          grant <= win_onehot;
        end else begin
          state <= IDLE;
          grant <= '0;
        end
      end else if (fifo_wr) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
